// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, owner
// identifiers and the timeout counter width.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IM = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  // Wide enough for any TIMEOUT in 2..255.
  localparam int unsigned CNT_W = 8;

  function automatic owner_e other_owner(input owner_e o);
    return (o == OWN_IM) ? OWN_DM : OWN_IM;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin selector: a sole requester wins, a tie goes to the
// requester that was not served last. Purely combinational.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic   im_req_i,
  input  logic   dm_req_i,
  input  owner_e last_owner_i,
  output owner_e owner_o
);

  always_comb begin
    owner_o = OWN_IM;
    if (im_req_i && dm_req_i) begin
      owner_o = other_owner(last_owner_i);
    end else if (dm_req_i) begin
      owner_o = OWN_DM;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one single-port memory,
// one transaction in flight, with a response timeout that returns an error.
//
// state | meaning
// IDLE  | no transaction; arbitrate and latch the winner's payload
// REQ   | o_mem_req high from latched payload, waiting for i_mem_gnt
// RESP  | granted, waiting for i_mem_rvalid or timeout
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_im_req,
  input  logic [XLEN-1:0]   i_im_addr,
  output logic              o_im_gnt,
  output logic              o_im_rvalid,
  output logic [XLEN-1:0]   o_im_rdata,
  output logic              o_im_err,
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [XLEN-1:0]   i_dm_addr,
  input  logic [XLEN-1:0]   i_dm_wdata,
  input  logic [XLEN/8-1:0] i_dm_wstrb,
  output logic              o_dm_gnt,
  output logic              o_dm_rvalid,
  output logic [XLEN-1:0]   o_dm_rdata,
  output logic              o_dm_err,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [XLEN/8-1:0] o_mem_wstrb,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [XLEN-1:0]   i_mem_rdata,
  output logic              o_busy
);

  localparam int SW = XLEN / 8;
  localparam logic [CNT_W-1:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            rr_owner;
  logic              we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]     wstrb_q, wstrb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   im_rdata_q, im_rdata_d;
  logic [XLEN-1:0]   dm_rdata_q, dm_rdata_d;
  logic              im_rvalid_q, im_rvalid_d;
  logic              dm_rvalid_q, dm_rvalid_d;
  logic              im_err_q, im_err_d;
  logic              dm_err_q, dm_err_d;

  rr_arbiter2 u_rr (
    .im_req_i     (i_im_req),
    .dm_req_i     (i_dm_req),
    .last_owner_i (owner_q),
    .owner_o      (rr_owner)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    cnt_d       = cnt_q;
    im_rdata_d  = im_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    im_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    im_err_d    = 1'b0;
    dm_err_d    = 1'b0;
    o_mem_req   = 1'b0;
    o_im_gnt    = 1'b0;
    o_dm_gnt    = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_im_req || i_dm_req) begin
          owner_d = rr_owner;
          state_d = REQ;
          if (rr_owner == OWN_IM) begin
            we_d    = 1'b0;
            addr_d  = i_im_addr;
            wdata_d = '0;
            wstrb_d = '0;
          end else begin
            we_d    = i_dm_we;
            addr_d  = i_dm_addr;
            wdata_d = i_dm_wdata;
            wstrb_d = i_dm_wstrb;
          end
        end
      end

      REQ: begin
        o_mem_req = 1'b1;
        if (i_mem_gnt) begin
          o_im_gnt = (owner_q == OWN_IM);
          o_dm_gnt = (owner_q == OWN_DM);
          cnt_d    = '0;
          state_d  = RESP;
        end
      end

      RESP: begin
        // A response in the final allowed cycle still wins over the timeout.
        if (i_mem_rvalid) begin
          state_d = IDLE;
          if (owner_q == OWN_IM) begin
            im_rdata_d  = i_mem_rdata;
            im_rvalid_d = 1'b1;
          end else begin
            dm_rdata_d  = i_mem_rdata;
            dm_rvalid_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          if (owner_q == OWN_IM) begin
            im_rdata_d  = '0;
            im_rvalid_d = 1'b1;
            im_err_d    = 1'b1;
          end else begin
            dm_rdata_d  = '0;
            dm_rvalid_d = 1'b1;
            dm_err_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_DM;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      cnt_q       <= '0;
      im_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      im_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      im_err_q    <= 1'b0;
      dm_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      cnt_q       <= cnt_d;
      im_rdata_q  <= im_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      im_rvalid_q <= im_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      im_err_q    <= im_err_d;
      dm_err_q    <= dm_err_d;
    end
  end

  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_wstrb = wstrb_q;
  assign o_im_rvalid = im_rvalid_q;
  assign o_im_rdata  = im_rdata_q;
  assign o_im_err    = im_err_q;
  assign o_dm_rvalid = dm_rvalid_q;
  assign o_dm_rdata  = dm_rdata_q;
  assign o_dm_err    = dm_err_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the address and data width.
REQ-002 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of RESP cycles allowed without i_mem_rvalid (range 2..255).
REQ-003 SHALL have ports, clock and reset first:
 clk  input  1  sole clock; all state updates on the rising edge
 rst  input  1  synchronous, active-high reset
 i_im_req  input  1  instruction-fetch read request
 i_im_addr  input  XLEN  fetch address
 o_im_gnt  output  1  fetch request accepted
 o_im_rvalid  output  1  fetch response valid (1-cycle pulse)
 o_im_rdata  output  XLEN  fetch response data
 o_im_err  output  1  fetch timed out; qualified by o_im_rvalid
 i_dm_req  input  1  data request
 i_dm_we  input  1  data write enable
 i_dm_addr  input  XLEN  data address
 i_dm_wdata  input  XLEN  write data
 i_dm_wstrb  input  XLEN/8  byte strobes
 o_dm_gnt  output  1  data request accepted
 o_dm_rvalid  output  1  data response/write-ack valid (1-cycle pulse)
 o_dm_rdata  output  XLEN  data response
 o_dm_err  output  1  data timed out; qualified by o_dm_rvalid
 o_mem_req  output  1  request to the unified single-port memory
 o_mem_we  output  1  write enable
 o_mem_addr  output  XLEN  address
 o_mem_wdata  output  XLEN  write data
 o_mem_wstrb  output  XLEN/8  byte strobes
 i_mem_gnt  input  1  memory accepts o_mem_req
 i_mem_rvalid  input  1  memory response or write ack
 i_mem_rdata  input  XLEN  memory read data
 o_busy  output  1  high whenever state != IDLE; core stall input

Function
REQ-004 SHALL implement FSM IDLE -> REQ -> RESP -> IDLE, with one transaction outstanding at most.
REQ-005 In IDLE, if any i_*_req is high, SHALL select an owner, latch that requester's addr/we/wdata/wstrb into registers (IM: we=0, wstrb=0), and go to REQ.
REQ-006 Arbitration SHALL be round-robin: a sole requester wins; on a tie, the requester not served last wins; last_owner SHALL update on each IDLE->REQ transition.
REQ-007 In REQ, o_mem_req SHALL be 1 and o_mem_* SHALL be driven from the latched registers; on i_mem_gnt, SHALL pulse the owner's o_*_gnt in that same cycle (combinational) and go to RESP.
REQ-008 Outside REQ, o_mem_req SHALL be 0 and both o_*_gnt SHALL be 0.
REQ-009 Requesters SHALL hold req and payload stable until their gnt; the arbiter does not need to sample the payload after IDLE.
REQ-010 In RESP, on i_mem_rvalid, SHALL register i_mem_rdata into the owner's rdata register, pulse the owner's o_*_rvalid for the next cycle with o_*_err=0, and go to IDLE.
REQ-011 Latency SHALL be: request seen in IDLE at cycle 0; o_mem_req at cycle 1; with gnt at cycle 1 and rvalid at cycle 2, o_*_rvalid at cycle 3; next arbitration at cycle 3.
REQ-012 o_im_rdata and o_dm_rdata SHALL hold their last value until that port's next response.
REQ-013 The timeout counter SHALL clear on entry to RESP and increment each RESP cycle without i_mem_rvalid.
REQ-014 On reaching TIMEOUT-1 the arbiter SHALL go to IDLE, pulse the owner's o_*_rvalid with o_*_err=1, and load 0 into the owner's rdata.
REQ-015 i_mem_rvalid SHALL be ignored in IDLE and REQ, so late responses are dropped.
REQ-016 i_mem_rvalid in the same cycle the counter reaches TIMEOUT-1 SHALL count as a normal response (err=0).
REQ-017 Writes SHALL complete via i_mem_rvalid; for a write, o_dm_rdata SHALL be loaded with i_mem_rdata unchanged.

Reset
REQ-018 While rst is high on a clock edge: state=IDLE, last_owner=DM (so IM wins the first tie), counter=0, all latched payload registers=0.
REQ-019 While rst is high on a clock edge: all o_*_gnt, o_*_rvalid, o_*_err, o_mem_req and o_busy=0, and o_*_rdata=0.
REQ-020 Reset asserted mid-transaction SHALL abandon it with no rvalid pulse.

Structure
REQ-021 A shared package SHALL hold the state enum (IDLE, REQ, RESP) and the owner enum (OWN_IM, OWN_DM).
REQ-022 Round-robin selection SHALL be one sub-module, rr_arbiter2 (combinational: two reqs plus last_owner in, owner out).
REQ-023 The FSM, counter and response registers SHALL reside in mem_arbiter.

Verification
REQ-024 IM req at addr 0x100, gnt immediate, rvalid next cycle with 0xDEADBEEF -> o_im_rvalid at cycle 3, o_im_rdata=0xDEADBEEF, err=0.
REQ-025 IM and DM request together from reset -> IM served first; next transaction goes to DM; with both held, owners alternate IM, DM, IM, DM.
REQ-026 DM write to 0x200, data 0x12345678, wstrb=0x3 -> o_mem_we=1, o_mem_wstrb=0x3, o_mem_addr=0x200 during REQ; ack -> o_dm_rvalid pulse.
REQ-027 i_mem_gnt withheld 5 cycles -> o_mem_req and payload stable throughout, o_busy=1, o_dm_gnt pulses only in the gnt cycle.
REQ-028 No rvalid for TIMEOUT=16 -> o_im_rvalid=1, o_im_err=1, o_im_rdata=0 after 16 RESP cycles; rvalid arriving later is ignored.
REQ-029 rst asserted in RESP -> next cycle IDLE with all outputs 0; a subsequent i_mem_rvalid produces no rvalid pulse.
